// File: rtl/l3_pkg.sv
// l3_pkg: shared constants and types for the L3 feeder stages
// Provides the grid data width, the arbiter state encoding and the FIFO entry layout.
package l3_pkg;
  localparam int L3_DW = 32;
  // Wide enough for up to 8 requester ports.
  localparam int L3_SRCW = 3;
  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;
  typedef struct packed {
    logic [L3_SRCW-1:0] src;
    logic [L3_DW-1:0]   data;
  } l3_entry_t;
endpackage

// File: rtl/l3_sync_fifo.sv
// l3_sync_fifo: power-of-two synchronous FIFO with occupancy count
// Ports: clk, rst (async, active high), push/din write the tail, pop/dout read the head,
// full/empty flags, count = occupancy 0..DEPTH. Push when full and pop when empty are ignored.
module l3_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 35,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/l3_bus_arbiter.sv
// l3_bus_arbiter: round-robin, burst-locking feeder from NREQ ports onto the L3 grid bus
// Ports: clk, rst (async, active high); req_valid/req_last/req_data per port, req_ready one-hot grant;
// bus_ready from the grid; bus_out/bus_valid/bus_src registered output word (all zero when idle);
// fifo_count = buffered words.
module l3_bus_arbiter
  import l3_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DEPTH = 4,
  parameter int DW = L3_DW,
  localparam int SW = $clog2(NREQ),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_last,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               bus_ready,
  output logic [DW-1:0]      bus_out,
  output logic               bus_valid,
  output logic [SW-1:0]      bus_src,
  output logic [CW-1:0]      fifo_count
);
  arb_state_e state_q, state_d;
  logic [SW-1:0] rr_q, rr_d, grant_q, grant_d, win, sel;
  logic win_v, ok, accept, full, empty, pop;
  logic [DW-1:0] bus_out_q;
  logic bus_valid_q;
  logic [SW-1:0] bus_src_q;
  l3_entry_t push_e, head;
  logic unused_src;
  // Port index addition modulo NREQ, correct for non-power-of-two NREQ.
  function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    return SW'(s >= NREQ ? s - NREQ : s);
  endfunction
  // Scan offsets high to low so the valid port nearest rr_q is the final assignment.
  always_comb begin
    win = '0;
    win_v = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_valid[wrap_add(rr_q, k)]) begin
        win = wrap_add(rr_q, k);
        win_v = 1'b1;
      end
  end
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    grant_d = grant_q;
    sel = state_q == ARB_BURST ? grant_q : win;
    ok = state_q == ARB_BURST || win_v;
    // Ready depends only on occupancy, never on a same-cycle pop.
    req_ready = (!rst && ok && !full) ? {{(NREQ-1){1'b0}}, 1'b1} << sel : '0;
    accept = ok && !full && req_valid[sel];
    if (accept) begin
      state_d = req_last[sel] ? ARB_IDLE : ARB_BURST;
      rr_d = req_last[sel] ? wrap_add(sel, 1) : rr_q;
      grant_d = sel;
    end
  end
  always_comb begin
    push_e.src = L3_SRCW'(sel);
    push_e.data = req_data[int'(sel)*DW +: DW];
  end
  assign pop = !empty && bus_ready;
  assign unused_src = ^head.src;
  l3_sync_fifo #(.DEPTH(DEPTH), .W($bits(l3_entry_t))) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .din   (push_e),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ARB_IDLE;
      rr_q <= '0;
      grant_q <= '0;
      bus_out_q <= '0;
      bus_valid_q <= 1'b0;
      bus_src_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      grant_q <= grant_d;
      bus_out_q <= pop ? head.data : '0;
      bus_valid_q <= pop;
      bus_src_q <= pop ? head.src[SW-1:0] : '0;
    end
  assign bus_out = bus_out_q;
  assign bus_valid = bus_valid_q;
  assign bus_src = bus_src_q;
endmodule

// File: tb/tb_l3_bus_arbiter.sv
// tb_l3_bus_arbiter: randomized self-checking bench against a queue-based reference model
module tb_l3_bus_arbiter;
  localparam int NREQ = 4, DEPTH = 4, DW = 32;
  logic clk = 1'b0, rst = 1'b0, bus_ready = 1'b1;
  logic [NREQ-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [DW-1:0] bus_out;
  logic bus_valid;
  logic [1:0] bus_src;
  logic [2:0] fifo_count;
  l3_bus_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .bus_ready(bus_ready), .bus_out(bus_out), .bus_valid(bus_valid),
    .bus_src(bus_src), .fifo_count(fifo_count)
  );
  always #5 clk = ~clk;
  typedef struct {int src; logic [DW-1:0] data;} ent_t;
  ent_t q[$];
  int rr = 0, lock = -1, cmp = 0, bad = 0;
  logic [NREQ-1:0] ready_seen, exp_ready;
  logic exp_valid;
  logic [1:0] exp_src;
  logic [DW-1:0] exp_out;
  logic [2:0] exp_count;
  // One clock of the reference model: whoever is locked (or the first valid from rr) may
  // take a word if the queue has room; the head leaves when bus_ready is high.
  task automatic step();
    int acc;
    ent_t e;
    #2;
    ready_seen = req_ready;
    exp_ready = '0;
    acc = -1;
    if (q.size() < DEPTH) begin
      if (lock >= 0) begin
        exp_ready[lock] = 1'b1;
        if (req_valid[lock]) acc = lock;
      end else
        for (int k = 0; k < NREQ; k++)
          if (acc < 0 && req_valid[(rr + k) % NREQ]) begin
            acc = (rr + k) % NREQ;
            exp_ready[acc] = 1'b1;
          end
    end
    exp_valid = 1'b0; exp_out = '0; exp_src = '0;
    if (q.size() > 0 && bus_ready) begin
      e = q.pop_front();
      exp_valid = 1'b1; exp_out = e.data; exp_src = 2'(e.src);
    end
    if (acc >= 0) begin
      e.src = acc; e.data = req_data[acc*DW +: DW];
      q.push_back(e);
      if (req_last[acc]) begin rr = (acc + 1) % NREQ; lock = -1; end
      else lock = acc;
    end
    exp_count = 3'(q.size());
    @(posedge clk);
    #1;
  endtask
  task automatic randomize_data();
    for (int p = 0; p < NREQ; p++) req_data[p*DW +: DW] = $urandom;
  endtask
  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    cmp++; if ({bus_valid, bus_src, bus_out, fifo_count, req_ready} !== '0) begin bad++; $display("FAIL reset_init: got v%b s%0d d%h n%0d r%b want all 0", bus_valid, bus_src, bus_out, fifo_count, req_ready); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus_ready = 1'b1; req_valid = '1; req_last = '1;
    for (int i = 0; i < 5; i++) begin
      randomize_data();
      step();
      cmp++; if (ready_seen !== exp_ready) begin bad++; $display("FAIL reset_ready c%0d: got %b want %b", i, ready_seen, exp_ready); end
      cmp++; if ({bus_valid, bus_src, bus_out, fifo_count} !== {exp_valid, exp_src, exp_out, exp_count}) begin bad++; $display("FAIL reset_bus c%0d: got v%b s%0d d%h n%0d want v%b s%0d d%h n%0d", i, bus_valid, bus_src, bus_out, fifo_count, exp_valid, exp_src, exp_out, exp_count); end
    end
    #2 rst = 1'b1;
    #1;
    cmp++; if ({bus_valid, bus_src, bus_out, fifo_count, req_ready} !== '0) begin bad++; $display("FAIL reset_async: got v%b s%0d d%h n%0d r%b want all 0", bus_valid, bus_src, bus_out, fifo_count, req_ready); end
    q.delete(); rr = 0; lock = -1;
    @(posedge clk);
    #2 rst = 1'b0;
    req_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      randomize_data();
      step();
      cmp++; if (ready_seen !== exp_ready) begin bad++; $display("FAIL reset_rr_ready c%0d: got %b want %b", i, ready_seen, exp_ready); end
      cmp++; if ({bus_valid, bus_src, bus_out, fifo_count} !== {exp_valid, exp_src, exp_out, exp_count}) begin bad++; $display("FAIL reset_rr_bus c%0d: got v%b s%0d d%h n%0d want v%b s%0d d%h n%0d", i, bus_valid, bus_src, bus_out, fifo_count, exp_valid, exp_src, exp_out, exp_count); end
    end
  endtask
  task automatic drain(input string tag);
    req_valid = '0; bus_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      step();
      cmp++; if ({bus_valid, bus_src, bus_out, fifo_count} !== {exp_valid, exp_src, exp_out, exp_count}) begin bad++; $display("FAIL %s_drain c%0d: got v%b s%0d d%h n%0d want v%b s%0d d%h n%0d", tag, i, bus_valid, bus_src, bus_out, fifo_count, exp_valid, exp_src, exp_out, exp_count); end
    end
  endtask
  task automatic test_round_robin();
    drain("rr");
    req_valid = '1; req_last = '1;
    for (int p = 0; p < NREQ; p++) req_data[p*DW +: DW] = p;
    for (int i = 0; i < 12; i++) begin
      step();
      cmp++; if (ready_seen !== exp_ready) begin bad++; $display("FAIL rr_ready c%0d: got %b want %b", i, ready_seen, exp_ready); end
      cmp++; if ({bus_valid, bus_src, bus_out, fifo_count} !== {exp_valid, exp_src, exp_out, exp_count}) begin bad++; $display("FAIL rr_bus c%0d: got v%b s%0d d%h n%0d want v%b s%0d d%h n%0d", i, bus_valid, bus_src, bus_out, fifo_count, exp_valid, exp_src, exp_out, exp_count); end
      if (i >= 1) begin
        cmp++; if (bus_valid !== 1'b1) begin bad++; $display("FAIL rr_stream c%0d: got valid %b want 1", i, bus_valid); end
      end
    end
  endtask
  task automatic test_burst_lock();
    logic [NREQ-1:0] vs [5] = '{4'b0100, 4'b0111, 4'b0111, 4'b1011, 4'b1011};
    logic [NREQ-1:0] ls [5] = '{4'b0011, 4'b0011, 4'b0111, 4'b1011, 4'b1011};
    drain("burst");
    for (int i = 0; i < 10; i++) begin
      req_valid = vs[i < 5 ? i : 4]; req_last = ls[i < 5 ? i : 4];
      randomize_data();
      step();
      cmp++; if (ready_seen !== exp_ready) begin bad++; $display("FAIL burst_ready c%0d: got %b want %b", i, ready_seen, exp_ready); end
      cmp++; if ({bus_valid, bus_src, bus_out, fifo_count} !== {exp_valid, exp_src, exp_out, exp_count}) begin bad++; $display("FAIL burst_bus c%0d: got v%b s%0d d%h n%0d want v%b s%0d d%h n%0d", i, bus_valid, bus_src, bus_out, fifo_count, exp_valid, exp_src, exp_out, exp_count); end
    end
  endtask
  task automatic test_full();
    drain("full");
    bus_ready = 1'b0; req_valid = 4'b0001; req_last = '1;
    for (int i = 0; i < 7; i++) begin
      randomize_data();
      step();
      cmp++; if (ready_seen !== exp_ready) begin bad++; $display("FAIL full_ready c%0d: got %b want %b", i, ready_seen, exp_ready); end
      cmp++; if ({bus_valid, bus_src, bus_out, fifo_count} !== {exp_valid, exp_src, exp_out, exp_count}) begin bad++; $display("FAIL full_bus c%0d: got v%b s%0d d%h n%0d want v%b s%0d d%h n%0d", i, bus_valid, bus_src, bus_out, fifo_count, exp_valid, exp_src, exp_out, exp_count); end
    end
    cmp++; if (fifo_count !== 3'd4 || req_ready !== '0 || bus_out !== '0) begin bad++; $display("FAIL full_hold: got n%0d r%b d%h want n4 r0000 d0", fifo_count, req_ready, bus_out); end
    drain("full");
  endtask
  task automatic test_push_pop();
    drain("pp");
    bus_ready = 1'b0; req_valid = 4'b0010; req_last = '1;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) bus_ready = 1'b1;
      randomize_data();
      step();
      cmp++; if (ready_seen !== exp_ready) begin bad++; $display("FAIL pp_ready c%0d: got %b want %b", i, ready_seen, exp_ready); end
      cmp++; if ({bus_valid, bus_src, bus_out, fifo_count} !== {exp_valid, exp_src, exp_out, exp_count}) begin bad++; $display("FAIL pp_bus c%0d: got v%b s%0d d%h n%0d want v%b s%0d d%h n%0d", i, bus_valid, bus_src, bus_out, fifo_count, exp_valid, exp_src, exp_out, exp_count); end
      if (i >= 1) begin
        cmp++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL pp_count c%0d: got %0d want 2", i, fifo_count); end
      end
    end
  endtask
  task automatic test_idle_zero();
    drain("idle");
    req_valid = 4'b0001; req_last = '1; req_data[0 +: DW] = 32'hDEADBEEF;
    step();
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      cmp++; if ({bus_valid, bus_src, bus_out, fifo_count} !== {exp_valid, exp_src, exp_out, exp_count}) begin bad++; $display("FAIL idle_bus c%0d: got v%b s%0d d%h n%0d want v%b s%0d d%h n%0d", i, bus_valid, bus_src, bus_out, fifo_count, exp_valid, exp_src, exp_out, exp_count); end
      cmp++; if (bus_out !== (i == 0 ? 32'hDEADBEEF : 32'h0)) begin bad++; $display("FAIL idle_word c%0d: got %h want %h", i, bus_out, i == 0 ? 32'hDEADBEEF : 32'h0); end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req_valid = NREQ'($urandom);
      for (int p = 0; p < NREQ; p++) req_last[p] = ($urandom % 3) == 0;
      bus_ready = ($urandom % 4) != 0;
      randomize_data();
      step();
      cmp++; if (ready_seen !== exp_ready) begin bad++; $display("FAIL rand_ready c%0d: got %b want %b", i, ready_seen, exp_ready); end
      cmp++; if ({bus_valid, bus_src, bus_out, fifo_count} !== {exp_valid, exp_src, exp_out, exp_count}) begin bad++; $display("FAIL rand_bus c%0d: got v%b s%0d d%h n%0d want v%b s%0d d%h n%0d", i, bus_valid, bus_src, bus_out, fifo_count, exp_valid, exp_src, exp_out, exp_count); end
    end
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_burst_lock();
    test_full();
    test_push_pop();
    test_idle_zero();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
